// File: rtl/pipeline_stage_regs_if.sv
// rtl/pipeline_stage_regs_if.sv - bundle of IF/ID, ID/EX and EX/MEM pipeline register signals
interface pipeline_stage_regs_if;
  logic [31:0] ifid_in_pc;
  logic [31:0] ifid_in_instruction;
  logic [31:0] ifid_out_pc;
  logic [31:0] ifid_out_instruction;

  logic [9:0]  idex_in_ctl;
  logic [4:0]  idex_in_rt;
  logic [4:0]  idex_in_rd;
  logic [31:0] idex_in_imm;
  logic [31:0] idex_in_pc;
  logic [31:0] idex_in_rd1;
  logic [31:0] idex_in_rd2;
  logic        idex_RegDst;
  logic        idex_ALUSrc;
  logic [1:0]  idex_ALUOp;
  logic        idex_Branch;
  logic [4:0]  idex_out_ctl;
  logic [4:0]  idex_out_rt;
  logic [4:0]  idex_out_rd;
  logic [31:0] idex_out_imm;
  logic [31:0] idex_out_pc;
  logic [31:0] idex_out_rd1;
  logic [31:0] idex_out_rd2;

  logic [4:0]  exmem_in_ctl;
  logic [31:0] exmem_in_b_tgt;
  logic [31:0] exmem_in_alu_out;
  logic [31:0] exmem_in_rd2;
  logic [31:0] exmem_in_pc;
  logic [4:0]  exmem_in_wn;
  logic        exmem_MemRead;
  logic        exmem_MemWrite;
  logic [2:0]  exmem_out_ctl;
  logic [31:0] exmem_out_b_tgt;
  logic [31:0] exmem_out_alu_out;
  logic [31:0] exmem_out_rd2;
  logic [31:0] exmem_out_pc;
  logic [4:0]  exmem_out_wn;

  // Stage logic side: drives the bank inputs and consumes the registered outputs.
  modport master (
    output ifid_in_pc, ifid_in_instruction,
    input  ifid_out_pc, ifid_out_instruction,
    output idex_in_ctl, idex_in_rt, idex_in_rd, idex_in_imm, idex_in_pc, idex_in_rd1, idex_in_rd2,
    input  idex_RegDst, idex_ALUSrc, idex_ALUOp, idex_Branch, idex_out_ctl,
    input  idex_out_rt, idex_out_rd, idex_out_imm, idex_out_pc, idex_out_rd1, idex_out_rd2,
    output exmem_in_ctl, exmem_in_b_tgt, exmem_in_alu_out, exmem_in_rd2, exmem_in_pc, exmem_in_wn,
    input  exmem_MemRead, exmem_MemWrite, exmem_out_ctl,
    input  exmem_out_b_tgt, exmem_out_alu_out, exmem_out_rd2, exmem_out_pc, exmem_out_wn
  );

  modport slave (
    input  ifid_in_pc, ifid_in_instruction,
    output ifid_out_pc, ifid_out_instruction,
    input  idex_in_ctl, idex_in_rt, idex_in_rd, idex_in_imm, idex_in_pc, idex_in_rd1, idex_in_rd2,
    output idex_RegDst, idex_ALUSrc, idex_ALUOp, idex_Branch, idex_out_ctl,
    output idex_out_rt, idex_out_rd, idex_out_imm, idex_out_pc, idex_out_rd1, idex_out_rd2,
    input  exmem_in_ctl, exmem_in_b_tgt, exmem_in_alu_out, exmem_in_rd2, exmem_in_pc, exmem_in_wn,
    output exmem_MemRead, exmem_MemWrite, exmem_out_ctl,
    output exmem_out_b_tgt, exmem_out_alu_out, exmem_out_rd2, exmem_out_pc, exmem_out_wn
  );
endinterface

// File: rtl/pipeline_stage_regs.sv
// rtl/pipeline_stage_regs.sv - IF/ID, ID/EX and EX/MEM register banks of the 5-stage MIPS core
module pipeline_stage_regs (
  input  logic                        clk,
  input  logic                        rst,
  pipeline_stage_regs_if.slave        bus
);

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ifid_out_pc          <= '0;
      bus.ifid_out_instruction <= '0;
    end else begin
      bus.ifid_out_pc          <= bus.ifid_in_pc;
      bus.ifid_out_instruction <= bus.ifid_in_instruction;
    end
  end

  // EX-stage controls are peeled off here; only the MEM/WB bits travel on.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.idex_RegDst  <= 1'b0;
      bus.idex_ALUSrc  <= 1'b0;
      bus.idex_ALUOp   <= 2'b00;
      bus.idex_Branch  <= 1'b0;
      bus.idex_out_ctl <= '0;
      bus.idex_out_rt  <= '0;
      bus.idex_out_rd  <= '0;
      bus.idex_out_imm <= '0;
      bus.idex_out_pc  <= '0;
      bus.idex_out_rd1 <= '0;
      bus.idex_out_rd2 <= '0;
    end else begin
      bus.idex_RegDst  <= bus.idex_in_ctl[9];
      bus.idex_ALUSrc  <= bus.idex_in_ctl[8];
      bus.idex_ALUOp   <= bus.idex_in_ctl[7:6];
      bus.idex_Branch  <= bus.idex_in_ctl[5];
      bus.idex_out_ctl <= bus.idex_in_ctl[4:0];
      bus.idex_out_rt  <= bus.idex_in_rt;
      bus.idex_out_rd  <= bus.idex_in_rd;
      bus.idex_out_imm <= bus.idex_in_imm;
      bus.idex_out_pc  <= bus.idex_in_pc;
      bus.idex_out_rd1 <= bus.idex_in_rd1;
      bus.idex_out_rd2 <= bus.idex_in_rd2;
    end
  end

  // MEM-stage controls are peeled off here; only the WB bits travel on.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.exmem_MemRead     <= 1'b0;
      bus.exmem_MemWrite    <= 1'b0;
      bus.exmem_out_ctl     <= '0;
      bus.exmem_out_b_tgt   <= '0;
      bus.exmem_out_alu_out <= '0;
      bus.exmem_out_rd2     <= '0;
      bus.exmem_out_pc      <= '0;
      bus.exmem_out_wn      <= '0;
    end else begin
      bus.exmem_MemRead     <= bus.exmem_in_ctl[4];
      bus.exmem_MemWrite    <= bus.exmem_in_ctl[3];
      bus.exmem_out_ctl     <= bus.exmem_in_ctl[2:0];
      bus.exmem_out_b_tgt   <= bus.exmem_in_b_tgt;
      bus.exmem_out_alu_out <= bus.exmem_in_alu_out;
      bus.exmem_out_rd2     <= bus.exmem_in_rd2;
      bus.exmem_out_pc      <= bus.exmem_in_pc;
      bus.exmem_out_wn      <= bus.exmem_in_wn;
    end
  end

endmodule

// File: tb/tb_pipeline_stage_regs.sv
// tb/tb_pipeline_stage_regs.sv - scoreboard bench for the pipeline stage register banks
module tb_pipeline_stage_regs;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  pipeline_stage_regs_if bus ();

  pipeline_stage_regs dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [63:0]  ifid;
    logic [147:0] idex;
    logic [137:0] exmem;
  } exp_t;

  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic r);
    exp_t e;
    logic [9:0] ic;
    logic [4:0] ec;
    ic = bus.idex_in_ctl;
    ec = bus.exmem_in_ctl;
    e.ifid  = {bus.ifid_in_pc, bus.ifid_in_instruction};
    // Observed layout: RegDst, ALUSrc, ALUOp, Branch, out_ctl, rt, rd, imm, pc, rd1, rd2
    e.idex  = {ic[9], ic[8], ic[7], ic[6], ic[5], ic[4], ic[3], ic[2], ic[1], ic[0],
               bus.idex_in_rt, bus.idex_in_rd, bus.idex_in_imm, bus.idex_in_pc,
               bus.idex_in_rd1, bus.idex_in_rd2};
    e.exmem = {ec[4], ec[3], ec[2], ec[1], ec[0], bus.exmem_in_b_tgt, bus.exmem_in_alu_out,
               bus.exmem_in_rd2, bus.exmem_in_pc, bus.exmem_in_wn};
    if (r) e = '0;
    return e;
  endfunction

  function automatic exp_t observe();
    exp_t o;
    o.ifid  = {bus.ifid_out_pc, bus.ifid_out_instruction};
    o.idex  = {bus.idex_RegDst, bus.idex_ALUSrc, bus.idex_ALUOp, bus.idex_Branch, bus.idex_out_ctl,
               bus.idex_out_rt, bus.idex_out_rd, bus.idex_out_imm, bus.idex_out_pc,
               bus.idex_out_rd1, bus.idex_out_rd2};
    o.exmem = {bus.exmem_MemRead, bus.exmem_MemWrite, bus.exmem_out_ctl, bus.exmem_out_b_tgt,
               bus.exmem_out_alu_out, bus.exmem_out_rd2, bus.exmem_out_pc, bus.exmem_out_wn};
    return o;
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge: push the model's prediction, then pop and compare after the edge.
  task automatic step(input string tag);
    exp_t e;
    exp_t o;
    sb.push_back(model(rst));
    @(posedge clk);
    #1;
    o = observe();
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_ifid"},  160'(o.ifid),  160'(e.ifid));
      chk({tag, "_idex"},  160'(o.idex),  160'(e.idex));
      chk({tag, "_exmem"}, 160'(o.exmem), 160'(e.exmem));
    end
  endtask

  task automatic drive_all(input logic [31:0] v);
    bus.ifid_in_pc          = v;
    bus.ifid_in_instruction = v;
    bus.idex_in_ctl         = v[9:0];
    bus.idex_in_rt          = v[4:0];
    bus.idex_in_rd          = v[4:0];
    bus.idex_in_imm         = v;
    bus.idex_in_pc          = v;
    bus.idex_in_rd1         = v;
    bus.idex_in_rd2         = v;
    bus.exmem_in_ctl        = v[4:0];
    bus.exmem_in_b_tgt      = v;
    bus.exmem_in_alu_out    = v;
    bus.exmem_in_rd2        = v;
    bus.exmem_in_pc         = v;
    bus.exmem_in_wn         = v[4:0];
  endtask

  task automatic drive_rand();
    logic [31:0] r;
    bus.ifid_in_pc          = $urandom;
    bus.ifid_in_instruction = $urandom;
    r = $urandom;
    bus.idex_in_ctl         = r[9:0];
    bus.idex_in_rt          = r[14:10];
    bus.idex_in_rd          = r[19:15];
    bus.exmem_in_ctl        = r[24:20];
    bus.exmem_in_wn         = r[29:25];
    bus.idex_in_imm         = $urandom;
    bus.idex_in_pc          = $urandom;
    bus.idex_in_rd1         = $urandom;
    bus.idex_in_rd2         = $urandom;
    bus.exmem_in_b_tgt      = $urandom;
    bus.exmem_in_alu_out    = $urandom;
    bus.exmem_in_rd2        = $urandom;
    bus.exmem_in_pc         = $urandom;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Reset with every input at all-ones.
    rst = 1'b1;
    drive_all(32'hFFFF_FFFF);
    step("reset");
    chk("reset_idex_out_ctl", 160'(bus.idex_out_ctl), 160'd0);
    chk("reset_exmem_memread", 160'(bus.exmem_MemRead), 160'd0);

    // Directed pass-through and control split.
    rst = 1'b0;
    drive_all(32'h0);
    bus.ifid_in_pc          = 32'h0000_0004;
    bus.ifid_in_instruction = 32'h8C01_0000;
    bus.idex_in_ctl         = 10'b1110100110;
    bus.idex_in_rt          = 5'd9;
    bus.idex_in_imm         = 32'hFFFF_FFF0;
    bus.exmem_in_ctl        = 5'b10011;
    bus.exmem_in_wn         = 5'd31;
    bus.exmem_in_alu_out    = 32'h0000_002C;
    step("directed");
    chk("ifid_pc",        160'(bus.ifid_out_pc),          160'h0000_0004);
    chk("ifid_instr",     160'(bus.ifid_out_instruction), 160'h8C01_0000);
    chk("idex_regdst",    160'(bus.idex_RegDst),  160'd1);
    chk("idex_alusrc",    160'(bus.idex_ALUSrc),  160'd1);
    chk("idex_aluop",     160'(bus.idex_ALUOp),   160'd2);
    chk("idex_branch",    160'(bus.idex_Branch),  160'd1);
    chk("idex_out_ctl",   160'(bus.idex_out_ctl), 160'b00110);
    chk("idex_rt",        160'(bus.idex_out_rt),  160'd9);
    chk("idex_imm",       160'(bus.idex_out_imm), 160'hFFFF_FFF0);
    chk("exmem_memread",  160'(bus.exmem_MemRead),  160'd1);
    chk("exmem_memwrite", 160'(bus.exmem_MemWrite), 160'd0);
    chk("exmem_out_ctl",  160'(bus.exmem_out_ctl),  160'b011);
    chk("exmem_wn",       160'(bus.exmem_out_wn),   160'd31);
    chk("exmem_alu_out",  160'(bus.exmem_out_alu_out), 160'h0000_002C);

    // Outputs must hold until the next edge even when inputs change.
    drive_all(32'h1234_5678);
    #3;
    chk("hold_ifid_pc",   160'(bus.ifid_out_pc),   160'h0000_0004);
    chk("hold_idex_ctl",  160'(bus.idex_out_ctl),  160'b00110);
    chk("hold_exmem_wn",  160'(bus.exmem_out_wn),  160'd31);
    step("hold_next");

    // Back-to-back streaming of distinct values.
    for (int i = 0; i < 4; i++) begin
      drive_rand();
      step("stream");
    end

    // A reset pulse between edges must be ignored.
    drive_rand();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    step("async_pulse");

    // Mid-stream single-edge reset, then recovery.
    drive_rand();
    step("pre_reset");
    drive_rand();
    rst = 1'b1;
    step("mid_reset");
    rst = 1'b0;
    drive_rand();
    step("post_reset");
    drive_rand();
    step("post_reset2");

    if (sb.size() != 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
